// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard control bundle.
// Carries the ID/EXE/MEM/WB stage status seen by the hazard controller,
// the memory-stage handshake, and the freeze/flush/forwarding controls
// plus performance counters returned to the pipeline.
// The pipeline datapath uses the master modport; the controller uses slave.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [3:0]       src1;
    logic [3:0]       src2;
    logic             two_src;
    logic             id_valid;
    logic [3:0]       EXE_Dest;
    logic [3:0]       MEM_Dest;
    logic [3:0]       WB_Dest;
    logic             EXE_WB_EN;
    logic             MEM_WB_EN;
    logic             WB_WB_EN;
    logic             EXE_MEM_R_EN;
    logic [3:0]       EXE_src1;
    logic [3:0]       EXE_src2;
    logic             B;
    logic             mem_req;
    logic             mem_ready;

    logic             freeze_IF;
    logic             freeze_ID;
    logic             flush_IF;
    logic             flush_ID;
    logic             freeze_all;
    logic [1:0]       sel_src1;
    logic [1:0]       sel_src2;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output src1, src2, two_src, id_valid,
        output EXE_Dest, MEM_Dest, WB_Dest,
        output EXE_WB_EN, MEM_WB_EN, WB_WB_EN, EXE_MEM_R_EN,
        output EXE_src1, EXE_src2, B, mem_req, mem_ready,
        input  freeze_IF, freeze_ID, flush_IF, flush_ID, freeze_all,
        input  sel_src1, sel_src2, mem_timeout, stall_count, flush_count
    );

    modport slave (
        input  src1, src2, two_src, id_valid,
        input  EXE_Dest, MEM_Dest, WB_Dest,
        input  EXE_WB_EN, MEM_WB_EN, WB_WB_EN, EXE_MEM_R_EN,
        input  EXE_src1, EXE_src2, B, mem_req, mem_ready,
        output freeze_IF, freeze_ID, flush_IF, flush_ID, freeze_all,
        output sel_src1, sel_src2, mem_timeout, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller.
// Produces freeze/flush strobes for the IF/ID and ID/EXE registers, holds
// the whole pipeline while the MEM-stage memory access is outstanding
// (with a watchdog that traps into a sticky error state), and keeps
// saturating stall/flush performance counters.
// Optional feature macro: FORWARDING_EN. When defined, EXE operand
// forwarding selects are generated and only load-use hazards stall ID.
// When undefined, every RAW hazard against EXE/MEM stalls and the
// forwarding selects are tied to the register file.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  pipe
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [15:0]      TIMEOUT_LIMIT = 16'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX       = {CNT_W{1'b1}};

    state_t           state_q;
    state_t           state_d;
    logic [15:0]      wait_q;
    logic [15:0]      wait_d;
    logic [15:0]      wait_inc;
    logic             timeout_q;
    logic             timeout_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    logic             mem_stall;
    logic             src1_hit;
    logic             src2_hit;
    logic             hazard;
    logic             branch_flush;
    logic [1:0]       sel1;
    logic [1:0]       sel2;

    logic             freeze_if_o;
    logic             freeze_id_o;
    logic             flush_if_o;
    logic             flush_id_o;
    logic             freeze_all_o;
    logic [1:0]       sel_src1_o;
    logic [1:0]       sel_src2_o;

    assign wait_inc = wait_q + 16'd1;

`ifdef FORWARDING_EN
    // With forwarding only a load in EXE feeding the ID instruction must stall.
    always_comb begin
        src1_hit = 1'b0;
        src2_hit = 1'b0;
        if (pipe.EXE_MEM_R_EN && pipe.EXE_WB_EN) begin
            src1_hit = (pipe.src1 == pipe.EXE_Dest);
            src2_hit = pipe.two_src && (pipe.src2 == pipe.EXE_Dest);
        end
    end

    // Forwarding select per EXE operand; the younger MEM result wins over WB.
    always_comb begin
        sel1 = 2'b00;
        sel2 = 2'b00;
        if (pipe.MEM_WB_EN && (pipe.EXE_src1 == pipe.MEM_Dest)) begin
            sel1 = 2'b01;
        end else if (pipe.WB_WB_EN && (pipe.EXE_src1 == pipe.WB_Dest)) begin
            sel1 = 2'b10;
        end
        if (pipe.MEM_WB_EN && (pipe.EXE_src2 == pipe.MEM_Dest)) begin
            sel2 = 2'b01;
        end else if (pipe.WB_WB_EN && (pipe.EXE_src2 == pipe.WB_Dest)) begin
            sel2 = 2'b10;
        end
    end
`else
    logic fwd_unused;

    // Without forwarding any pending write in EXE or MEM to an ID source stalls.
    always_comb begin
        src1_hit = (pipe.EXE_WB_EN && (pipe.src1 == pipe.EXE_Dest))
                || (pipe.MEM_WB_EN && (pipe.src1 == pipe.MEM_Dest));
        src2_hit = pipe.two_src
                && ((pipe.EXE_WB_EN && (pipe.src2 == pipe.EXE_Dest))
                 || (pipe.MEM_WB_EN && (pipe.src2 == pipe.MEM_Dest)));
    end

    assign sel1 = 2'b00;
    assign sel2 = 2'b00;

    assign fwd_unused = ^{pipe.EXE_MEM_R_EN, pipe.EXE_src1, pipe.EXE_src2,
                          pipe.WB_Dest, pipe.WB_WB_EN};
`endif

    assign hazard = pipe.id_valid && (src1_hit || src2_hit);

    // Memory stall request: starts combinationally in IDLE, persists in MEM_WAIT, sticks in ERROR.
    always_comb begin
        mem_stall = 1'b0;
        case (state_q)
            IDLE:     mem_stall = pipe.mem_req && !pipe.mem_ready;
            MEM_WAIT: mem_stall = !pipe.mem_ready;
            ERROR:    mem_stall = 1'b1;
            default:  mem_stall = 1'b0;
        endcase
    end

    assign branch_flush = pipe.B && !mem_stall;

    // Next-state logic for the memory wait FSM and its watchdog.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (pipe.mem_req && !pipe.mem_ready) begin
                    state_d = MEM_WAIT;
                    wait_d  = 16'd0;
                end
            end
            MEM_WAIT: begin
                if (pipe.mem_ready) begin
                    state_d = IDLE;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == TIMEOUT_LIMIT) begin
                        state_d   = ERROR;
                        timeout_d = 1'b1;
                    end
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Saturating performance counters: stalls from memory or hazards, flushes from taken branches.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((mem_stall || hazard) && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (branch_flush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // Prioritised stage controls: memory stall, then branch flush, then hazard bubble; all quiet in reset.
    always_comb begin
        freeze_if_o  = 1'b0;
        freeze_id_o  = 1'b0;
        flush_if_o   = 1'b0;
        flush_id_o   = 1'b0;
        freeze_all_o = 1'b0;
        sel_src1_o   = 2'b00;
        sel_src2_o   = 2'b00;
        if (!rst) begin
            sel_src1_o = sel1;
            sel_src2_o = sel2;
            if (mem_stall) begin
                freeze_all_o = 1'b1;
                freeze_if_o  = 1'b1;
                freeze_id_o  = 1'b1;
            end else if (pipe.B) begin
                flush_if_o = 1'b1;
                flush_id_o = 1'b1;
            end else begin
                freeze_if_o = hazard;
                freeze_id_o = hazard;
                flush_id_o  = hazard;
            end
        end
    end

    // State, watchdog, error flag and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_q      <= 16'd0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pipe.freeze_IF   = freeze_if_o;
    assign pipe.freeze_ID   = freeze_id_o;
    assign pipe.flush_IF    = flush_if_o;
    assign pipe.flush_ID    = flush_id_o;
    assign pipe.freeze_all  = freeze_all_o;
    assign pipe.sel_src1    = sel_src1_o;
    assign pipe.sel_src2    = sel_src2_o;
    assign pipe.mem_timeout = timeout_q;
    assign pipe.stall_count = stall_cnt_q;
    assign pipe.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl.
// dutA uses the default watchdog limit; dutT shares every input with dutA
// but has a 3-cycle watchdog. Both use 4-bit counters so saturation is reachable.
module tb_pipeline_hazard_ctrl;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [3:0] src1;
        logic [3:0] src2;
        logic       twoSrc;
        logic       idValid;
        logic [3:0] exeDest;
        logic [3:0] memDest;
        logic [3:0] wbDest;
        logic       exeWbEn;
        logic       memWbEn;
        logic       wbWbEn;
        logic       exeLoad;
        logic [3:0] exeSrc1;
        logic [3:0] exeSrc2;
        logic       b;
        logic       hazNoFwd;
        logic       hazFwd;
        logic [1:0] sel1Fwd;
        logic [1:0] sel2Fwd;
    } vec_t;

    logic clk;
    logic rst;
    int   checkCount;
    int   passCount;
    vec_t vecs [13];

    pipeline_hazard_ctrl_if #(.CNT_W(4)) ifA ();
    pipeline_hazard_ctrl_if #(.CNT_W(4)) ifT ();

    assign ifT.src1         = ifA.src1;
    assign ifT.src2         = ifA.src2;
    assign ifT.two_src      = ifA.two_src;
    assign ifT.id_valid     = ifA.id_valid;
    assign ifT.EXE_Dest     = ifA.EXE_Dest;
    assign ifT.MEM_Dest     = ifA.MEM_Dest;
    assign ifT.WB_Dest      = ifA.WB_Dest;
    assign ifT.EXE_WB_EN    = ifA.EXE_WB_EN;
    assign ifT.MEM_WB_EN    = ifA.MEM_WB_EN;
    assign ifT.WB_WB_EN     = ifA.WB_WB_EN;
    assign ifT.EXE_MEM_R_EN = ifA.EXE_MEM_R_EN;
    assign ifT.EXE_src1     = ifA.EXE_src1;
    assign ifT.EXE_src2     = ifA.EXE_src2;
    assign ifT.B            = ifA.B;
    assign ifT.mem_req      = ifA.mem_req;
    assign ifT.mem_ready    = ifA.mem_ready;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(255), .CNT_W(4)) dutA (
        .clk  (clk),
        .rst  (rst),
        .pipe (ifA)
    );

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(3), .CNT_W(4)) dutT (
        .clk  (clk),
        .rst  (rst),
        .pipe (ifT)
    );

    logic [4:0] ctlA;
    logic [4:0] ctlT;
    logic [3:0] selA;
    assign ctlA = {ifA.freeze_IF, ifA.freeze_ID, ifA.flush_IF, ifA.flush_ID, ifA.freeze_all};
    assign ctlT = {ifT.freeze_IF, ifT.freeze_ID, ifT.flush_IF, ifT.flush_ID, ifT.freeze_all};
    assign selA = {ifA.sel_src1, ifA.sel_src2};

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] expCtl(input logic haz, input logic b, input logic stall);
        if (stall)  return 5'b11001;
        else if (b) return 5'b00110;
        else        return {haz, haz, 1'b0, haz, 1'b0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic setIdle();
        ifA.src1 = 4'd0;  ifA.src2 = 4'd0;  ifA.two_src = 1'b0;  ifA.id_valid = 1'b0;
        ifA.EXE_Dest = 4'd0;  ifA.MEM_Dest = 4'd0;  ifA.WB_Dest = 4'd0;
        ifA.EXE_WB_EN = 1'b0;  ifA.MEM_WB_EN = 1'b0;  ifA.WB_WB_EN = 1'b0;
        ifA.EXE_MEM_R_EN = 1'b0;  ifA.EXE_src1 = 4'd0;  ifA.EXE_src2 = 4'd0;
        ifA.B = 1'b0;  ifA.mem_req = 1'b0;  ifA.mem_ready = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        ifA.src1 = v.src1;  ifA.src2 = v.src2;  ifA.two_src = v.twoSrc;  ifA.id_valid = v.idValid;
        ifA.EXE_Dest = v.exeDest;  ifA.MEM_Dest = v.memDest;  ifA.WB_Dest = v.wbDest;
        ifA.EXE_WB_EN = v.exeWbEn;  ifA.MEM_WB_EN = v.memWbEn;  ifA.WB_WB_EN = v.wbWbEn;
        ifA.EXE_MEM_R_EN = v.exeLoad;  ifA.EXE_src1 = v.exeSrc1;  ifA.EXE_src2 = v.exeSrc2;
        ifA.B = v.b;
    endtask

    task automatic doReset();
        @(negedge clk);
        setIdle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int expStall;
        int expFlush;
        logic haz;
        checkCount = 0;
        passCount  = 0;

        //          src1  src2  two   idv   eDst  mDst  wDst  eWE   mWE   wWE   eLd   eS1   eS2   B     hNo   hFw   sel1   sel2
        vecs[0]  = '{4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00};
        vecs[1]  = '{4'd3, 4'd0, 1'b0, 1'b0, 4'd3, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[2]  = '{4'd7, 4'd0, 1'b0, 1'b1, 4'd0, 4'd7, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 4'd2, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00};
        vecs[3]  = '{4'd1, 4'd9, 1'b0, 1'b1, 4'd9, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[4]  = '{4'd1, 4'd9, 1'b1, 1'b1, 4'd9, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00};
        vecs[5]  = '{4'd1, 4'd9, 1'b1, 1'b1, 4'd9, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00};
        vecs[6]  = '{4'd4, 4'd0, 1'b0, 1'b1, 4'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[7]  = '{4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd5, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
        vecs[8]  = '{4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd5, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00};
        vecs[9]  = '{4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd3, 4'd6, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 4'd6, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10};
        vecs[10] = '{4'd1, 4'd9, 1'b1, 1'b1, 4'd9, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00};
        vecs[11] = '{4'd8, 4'd0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[12] = '{4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd3, 4'd6, 1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 4'd3, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01};

        // Reset with busy memory, hazard, branch and forwarding matches all active
        rst = 1'b1;
        setIdle();
        applyStimulus(vecs[2]);
        ifA.B = 1'b1;
        ifA.mem_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_ctlA", 32'(ctlA), 32'd0);
        checkOutput("rst_selA", 32'(selA), 32'd0);
        checkOutput("rst_stallA", 32'(ifA.stall_count), 32'd0);
        checkOutput("rst_flushA", 32'(ifA.flush_count), 32'd0);
        checkOutput("rst_toA", 32'(ifA.mem_timeout), 32'd0);
        checkOutput("rst_ctlT", 32'(ctlT), 32'd0);
        setIdle();
        @(negedge clk);
        rst = 1'b0;

        // Single EXE RAW hazard cycle, then stall counter
        @(negedge clk);
        applyStimulus(vecs[0]);
        #1;
        checkOutput("raw1_ctl", 32'(ctlA), 32'(expCtl(FWD ? 1'b0 : 1'b1, 1'b0, 1'b0)));
        @(negedge clk);
        setIdle();
        #1;
        checkOutput("raw1_stall_cnt", 32'(ifA.stall_count), FWD ? 32'd0 : 32'd1);

        // Table of combinational vectors with a counter model
        doReset();
        expStall = 0;
        expFlush = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            haz = FWD ? vecs[i].hazFwd : vecs[i].hazNoFwd;
            checkOutput($sformatf("vec%0d_ctl", i), 32'(ctlA), 32'(expCtl(haz, vecs[i].b, 1'b0)));
            checkOutput($sformatf("vec%0d_sel", i), 32'(selA),
                        FWD ? 32'({vecs[i].sel1Fwd, vecs[i].sel2Fwd}) : 32'd0);
            if (haz && expStall != 15) expStall++;
            if (vecs[i].b && expFlush != 15) expFlush++;
        end
        @(negedge clk);
        setIdle();
        #1;
        checkOutput("table_stall_cnt", 32'(ifA.stall_count), 32'(expStall));
        checkOutput("table_flush_cnt", 32'(ifA.flush_count), 32'(expFlush));

        // Memory stall of 4 cycles with a branch waiting in EXE
        doReset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ifA.mem_req = 1'b1;
            ifA.mem_ready = 1'b0;
            ifA.B = 1'b1;
            #1;
            checkOutput($sformatf("memstall_c%0d", c), 32'(ctlA), 32'(5'b11001));
        end
        @(negedge clk);
        ifA.mem_ready = 1'b1;
        #1;
        checkOutput("memstall_ready", 32'(ctlA), 32'(5'b00110));
        @(negedge clk);
        setIdle();
        #1;
        checkOutput("memstall_idle", 32'(ctlA), 32'd0);
        checkOutput("memstall_stall_cnt", 32'(ifA.stall_count), 32'd4);
        checkOutput("memstall_flush_cnt", 32'(ifA.flush_count), 32'd1);
        @(negedge clk);
        ifA.mem_req = 1'b1;
        ifA.mem_ready = 1'b1;
        #1;
        checkOutput("memhit_ctl", 32'(ctlA), 32'd0);
        @(negedge clk);
        setIdle();
        #1;
        checkOutput("memhit_stall_cnt", 32'(ifA.stall_count), 32'd4);

        // Watchdog on dutT: 3 MEM_WAIT cycles then sticky ERROR
        doReset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ifA.mem_req = 1'b1;
            ifA.mem_ready = 1'b0;
            #1;
            checkOutput($sformatf("wd_to_c%0d", c), 32'(ifT.mem_timeout), 32'd0);
            checkOutput($sformatf("wd_ctl_c%0d", c), 32'(ctlT), 32'(5'b11001));
        end
        @(negedge clk);
        #1;
        checkOutput("wd_to_set", 32'(ifT.mem_timeout), 32'd1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            ifA.mem_req = 1'b0;
            ifA.mem_ready = 1'b1;
            #1;
            checkOutput($sformatf("wd_stuck_c%0d", c), 32'(ctlT), 32'(5'b11001));
            checkOutput($sformatf("wd_to_stuck_c%0d", c), 32'(ifT.mem_timeout), 32'd1);
        end
        // Mid-cycle reset must clear the error without waiting for a clock edge
        rst = 1'b1;
        #1;
        checkOutput("wd_async_to", 32'(ifT.mem_timeout), 32'd0);
        checkOutput("wd_async_ctl", 32'(ctlT), 32'd0);
        @(negedge clk);
        setIdle();
        rst = 1'b0;
        #1;
        checkOutput("wd_post_ctl", 32'(ctlT), 32'd0);
        checkOutput("wd_post_stall", 32'(ifT.stall_count), 32'd0);

        // Counter saturation over 20 cycles
        doReset();
        @(negedge clk);
        applyStimulus(vecs[5]);
        repeat (20) @(negedge clk);
        setIdle();
        #1;
        checkOutput("sat_stall_cnt", 32'(ifA.stall_count), 32'd15);
        ifA.B = 1'b1;
        repeat (20) @(negedge clk);
        setIdle();
        #1;
        checkOutput("sat_flush_cnt", 32'(ifA.flush_count), 32'd15);
        checkOutput("sat_stall_hold", 32'(ifA.stall_count), 32'd15);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline control block that generates the freeze and flush strobes consumed by the IF/ID and ID/EXE stage registers, plus EXE-stage forwarding selects. It detects RAW hazards between the instruction in ID and those in EXE/MEM, flushes on a taken branch resolved in EXE, and holds the whole pipeline while the MEM-stage memory interface is busy, with a timeout watchdog. It also keeps stall and flush performance counters.

## Interface
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before the error trap; legal range 1..65535.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  reset; one clock, asynchronous, active-high
- src1, src2  in  4  ID-stage source register numbers
- two_src  in  1  ID instruction reads src2
- id_valid  in  1  ID holds a real instruction; hazards are ignored when 0
- EXE_Dest, MEM_Dest, WB_Dest  in  4  destination register in each stage
- EXE_WB_EN, MEM_WB_EN, WB_WB_EN  in  1  write-back enable in each stage
- EXE_MEM_R_EN  in  1  EXE instruction is a load
- EXE_src1, EXE_src2  in  4  source registers of the instruction in EXE (forwarding)
- B  in  1  taken branch in EXE
- mem_req  in  1  MEM stage performs a load or store
- mem_ready  in  1  memory interface completes the access this cycle
- freeze_IF, freeze_ID  out  1  hold the PC and IF/ID register
- flush_IF, flush_ID  out  1  clear the IF/ID and ID/EXE registers
- freeze_all  out  1  hold every pipeline register (memory stall)
- sel_src1, sel_src2  out  2  EXE operand select: 00 register file, 01 MEM-stage result, 10 WB result
- mem_timeout  out  1  sticky error flag
- stall_count, flush_count  out  CNT_W  performance counters

## Operation
- FSM states: IDLE, MEM_WAIT, ERROR. IDLE -> MEM_WAIT when mem_req && !mem_ready; MEM_WAIT -> IDLE when mem_ready; MEM_WAIT -> ERROR when the wait counter reaches MEM_TIMEOUT with mem_ready still 0. ERROR exits only on rst.
- Wait counter is 16 bits. It clears on entry to MEM_WAIT and increments each MEM_WAIT cycle.
- freeze_all = (IDLE && mem_req && !mem_ready) || (MEM_WAIT && !mem_ready) || ERROR.
- RAW hazard, without forwarding: id_valid && ((EXE_WB_EN && src1==EXE_Dest) || (MEM_WB_EN && src1==MEM_Dest)). The same terms apply to src2, gated by two_src.
- Priority, highest first:
  - freeze_all forces flush_IF = flush_ID = 0 and freeze_IF = freeze_ID = 1. A branch held in EXE flushes after the stall.
  - B forces flush_IF = flush_ID = 1 and freeze_IF = freeze_ID = 0. The hazard is discarded.
  - Otherwise freeze_IF = freeze_ID = hazard, and flush_ID = hazard, which inserts a bubble into ID/EXE.
- stall_count increments on every cycle with freeze_all || hazard, saturating at all-ones. flush_count increments on every cycle with a B-flush, also saturating.
- mem_timeout is set on entry to ERROR and cleared only by rst.

## Timing
- All freeze, flush and select outputs are combinational from the current inputs and state. They must be valid in the same cycle so the stage registers sample them on the next edge.
- FSM state, the wait counter, mem_timeout and the performance counters are registered and update on the rising clk edge.
- Reset values:
  - state = IDLE, counters = 0, mem_timeout = 0.
  - With rst=1, all freeze and flush outputs are 0 and sel_src1/sel_src2 = 00.
- rst during MEM_WAIT or ERROR returns the FSM to IDLE immediately (asynchronously).
- mem_req && mem_ready in the same IDLE cycle produces no stall cycle.

## Configuration
- FORWARDING_EN defined:
  - The hazard term reduces to the load-use case: id_valid && EXE_MEM_R_EN && EXE_WB_EN && Dest match, for src1, or src2 with two_src.
  - sel_srcN = 01 if MEM_WB_EN && EXE_srcN==MEM_Dest; else 10 if WB_WB_EN && EXE_srcN==WB_Dest; else 00. MEM has priority over WB.
- FORWARDING_EN undefined: the full RAW hazard rule applies and sel_src1 = sel_src2 = 00 at all times.

## Test plan
- No forwarding:
  - Stimulus: src1=3, EXE_Dest=3, EXE_WB_EN=1, id_valid=1.
  - Response: freeze_IF = freeze_ID = flush_ID = 1. Next cycle stall_count = 1.
- Forwarding:
  - Stimulus: EXE_src1=5, MEM_Dest=5, MEM_WB_EN=1, WB_Dest=5, WB_WB_EN=1.
  - Response: sel_src1 = 01. With MEM_WB_EN=0, sel_src1 = 10.
  - Load-use variant: EXE_MEM_R_EN=1 with a src2 match and two_src=1 gives a 1-cycle freeze.
- Branch:
  - Stimulus: B=1 together with an active hazard.
  - Response: flush_IF = flush_ID = 1, freezes = 0, flush_count increments by 1.
- Memory stall:
  - Stimulus: mem_req=1, mem_ready=0 for 4 cycles, then mem_ready=1.
  - Response: freeze_all = 1 for exactly 4 cycles and B is ignored during the stall. The FSM is back in IDLE after the ready cycle.
- Timeout:
  - Stimulus: MEM_TIMEOUT=3, mem_ready held at 0.
  - Response: ERROR entered and mem_timeout = 1 after 3 MEM_WAIT cycles, with freeze_all stuck at 1. A rst pulse clears everything to the reset values.
- Counter saturation:
  - Stimulus: CNT_W=4 with 20 hazard cycles.
  - Response: stall_count = 15.
